// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared defaults, handshake states and divisor helper for baud_gen
package baud_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OSR_DEF    = 16;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_PEND = 1'b1
  } hs_state_t;

  // Integer system clocks per oversample tick, truncated.
  function automatic int div_from_rate(input longint clk_hz, input longint baud, input int osr);
    return int'(clk_hz / (baud * longint'(osr)));
  endfunction

  localparam int DEFAULT_DIV = div_from_rate(50_000_000, 9600, OSR_DEF);

endpackage

// File: rtl/baud_frac_acc.sv
// rtl/baud_frac_acc.sv - fractional divisor accumulator; carry stretches the next oversample period
module baud_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, frac};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (step) begin
      acc   <= sum[FRAC_W-1:0];
      carry <= sum[FRAC_W];
    end
  end

endmodule

// File: rtl/baud_gen.sv
// rtl/baud_gen.sv - programmable UART baud generator (oversample tick, baud tick, baud clock)
// Optional fractional divisor enabled by defining BAUD_FRAC_EN.
module baud_gen #(
  parameter int DIV_W       = baud_pkg::DIV_W_DEF,
  parameter int FRAC_W      = baud_pkg::FRAC_W_DEF,
  parameter int OSR         = baud_pkg::OSR_DEF,
  parameter int DEFAULT_DIV = baud_pkg::DEFAULT_DIV
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_ack,
  input  logic              rx_align,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              clk_baud
);

  import baud_pkg::*;

  localparam int CC_W = DIV_W + 1;
  localparam int OC_W = $clog2(OSR);

  hs_state_t        hs_state;
  logic [DIV_W-1:0] div_cur;
  logic [DIV_W-1:0] pend_int;
  logic [CC_W-1:0]  cc;
  logic [CC_W-1:0]  d_eff;
  logic [CC_W-1:0]  last;
  logic [OC_W-1:0]  oc;
  logic             extra;
  logic             tick;
  logic             apply;

  assign d_eff = (div_cur < DIV_W'(2)) ? CC_W'(2) : CC_W'(div_cur);
  assign last  = d_eff - CC_W'(1) + CC_W'(extra);

  // >= so that a divisor shrunk while counting still ends the period at once.
  assign tick  = en & ~rx_align & (cc >= last);
  assign apply = (hs_state == HS_PEND) & (tick | rx_align | ~en);

  assign os_tick   = tick;
  assign baud_tick = tick & (oc == OC_W'(OSR - 1));
  assign div_ack   = apply;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cc       <= '0;
      oc       <= '0;
      clk_baud <= 1'b0;
    end else if (rx_align) begin
      cc       <= '0;
      oc       <= '0;
      clk_baud <= 1'b0;
    end else if (en) begin
      if (tick) begin
        cc <= '0;
        oc <= (oc == OC_W'(OSR - 1)) ? '0 : oc + OC_W'(1);
        if (oc == OC_W'(OSR / 2 - 1)) begin
          clk_baud <= 1'b1;
        end else if (oc == OC_W'(OSR - 1)) begin
          clk_baud <= 1'b0;
        end
      end else begin
        cc <= cc + CC_W'(1);
      end
    end
  end

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_cur;
  logic [FRAC_W-1:0] pend_frac;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frac_cur  <= '0;
      pend_frac <= '0;
    end else begin
      if (apply) begin
        frac_cur <= pend_frac;
      end
      if (div_load) begin
        pend_frac <= div_frac;
      end
    end
  end

  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (rx_align),
    .step   (tick),
    .frac   (frac_cur),
    .carry  (extra)
  );
`else
  logic unused_frac;

  assign unused_frac = ^div_frac;
  assign extra       = 1'b0;
`endif

  // A load coinciding with an apply lands in the pending regs after the old value is consumed.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hs_state <= HS_IDLE;
      div_cur  <= DIV_W'(DEFAULT_DIV);
      pend_int <= '0;
    end else begin
      if (apply) begin
        div_cur <= pend_int;
      end
      if (div_load) begin
        pend_int <= div_int;
        hs_state <= HS_PEND;
      end else if (apply) begin
        hs_state <= HS_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen.sv
// tb/tb_baud_gen.sv - self-checking bench for baud_gen: per-cycle reference model plus directed scenarios
module tb_baud_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;
  localparam int DEFDIV = 325;

  logic              clk_in   = 1'b0;
  logic              rst_in   = 1'b1;
  logic              en       = 1'b0;
  logic [DIV_W-1:0]  div_int  = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_load = 1'b0;
  logic              rx_align = 1'b0;
  logic              div_ack;
  logic              os_tick;
  logic              baud_tick;
  logic              clk_baud;

  int vectors = 0;
  int errors  = 0;

  always #5 clk_in = ~clk_in;

  baud_gen #(
    .DIV_W       (DIV_W),
    .FRAC_W      (FRAC_W),
    .OSR         (OSR),
    .DEFAULT_DIV (DEFDIV)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en        (en),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .div_load  (div_load),
    .div_ack   (div_ack),
    .rx_align  (rx_align),
    .os_tick   (os_tick),
    .baud_tick (baud_tick),
    .clk_baud  (clk_baud)
  );

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: divisor as a number, period length in enabled cycles,
  // tick count since the last align; clk_baud follows from the tick count.
  int m_div, m_frac, m_pend_div, m_pend_frac, m_elapsed, m_ticks, m_acc, m_extra;
  bit m_pend;

  always @(negedge clk_in) begin : model
    int  d, len, sum;
    bit  e_os, e_baud, e_clk, e_ack;
    if (rst_in) begin
      m_div = DEFDIV; m_frac = 0; m_pend = 0; m_pend_div = 0; m_pend_frac = 0;
      m_elapsed = 0; m_ticks = 0; m_acc = 0; m_extra = 0;
      check("rst_os_tick", os_tick, 0);
      check("rst_baud_tick", baud_tick, 0);
      check("rst_clk_baud", clk_baud, 0);
      check("rst_div_ack", div_ack, 0);
    end else begin
      d      = (m_div < 2) ? 2 : m_div;
      len    = d + m_extra;
      e_os   = en && !rx_align && (m_elapsed + 1 >= len);
      e_baud = e_os && ((m_ticks % OSR) == OSR - 1);
      e_clk  = (m_ticks % OSR) >= OSR / 2;
      e_ack  = m_pend && (e_os || rx_align || !en);
      check("model_os_tick", os_tick, e_os);
      check("model_baud_tick", baud_tick, e_baud);
      check("model_clk_baud", clk_baud, e_clk);
      check("model_div_ack", div_ack, e_ack);
      if (rx_align) begin
        m_elapsed = 0; m_ticks = 0; m_acc = 0; m_extra = 0;
      end else if (en) begin
        if (e_os) begin
          m_elapsed = 0;
          m_ticks++;
          sum = m_acc + m_frac;
          m_extra = (sum >= (1 << FRAC_W)) ? 1 : 0;
          m_acc = sum % (1 << FRAC_W);
        end else begin
          m_elapsed++;
        end
      end
      if (e_ack) begin
        m_div = m_pend_div;
`ifdef BAUD_FRAC_EN
        m_frac = m_pend_frac;
`endif
        m_pend = 0;
      end
      if (div_load) begin
        m_pend = 1;
        m_pend_div = int'(div_int);
        m_pend_frac = int'(div_frac);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Cycles until os_tick (tick cycle included); returns aligned to the next cycle start.
  task automatic wait_tick(output int n, output int acks, output logic ack_at);
    n = 0;
    acks = 0;
    forever begin
      @(negedge clk_in);
      n++;
      if (div_ack) acks++;
      if (os_tick || n >= 2000) break;
    end
    ack_at = div_ack;
    @(posedge clk_in);
    #1;
  endtask

  initial begin : stim
    int   n, acks, hi, ot, bt, total;
    logic ack_at;

    cyc(3);
    rst_in = 1'b0;
    en = 1'b1;
    wait_tick(n, acks, ack_at);
    check("boot_first_tick", n, 325);
    check("boot_no_ack", acks, 0);

    // divisor 4 applied through an align
    div_int = 16'd4; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0; rx_align = 1'b1;
    @(negedge clk_in);
    check("align_ack", div_ack, 1);
    check("align_no_tick", os_tick, 0);
    cyc(1);
    rx_align = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n, acks, ack_at);
      check("d4_period", n, 4);
    end
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!baud_tick && n < 200);
    check("d4_first_baud", n, 48);
    @(posedge clk_in);
    #1;
    hi = 0; ot = 0; bt = 0;
    repeat (64) begin
      @(negedge clk_in);
      hi += int'(clk_baud);
      ot += int'(os_tick);
      bt += int'(baud_tick);
    end
    check("d4_clk_high", hi, 32);
    check("d4_os_per_baud", ot, 16);
    check("d4_baud_count", bt, 1);
    check("d4_baud_at_64", baud_tick, 1);
    @(posedge clk_in);
    #1;

    // load at cc=1, reload at cc=2, single ack at the cc=3 tick
    cyc(1);
    div_int = 16'd5; div_load = 1'b1;
    cyc(1);
    div_int = 16'd6;
    cyc(1);
    div_load = 1'b0;
    wait_tick(n, acks, ack_at);
    check("reload_old_end", n, 1);
    check("reload_ack_at_tick", ack_at, 1);
    for (int i = 0; i < 8; i++) begin
      wait_tick(n, acks, ack_at);
      check("d6_period", n, 6);
      check("d6_no_second_ack", acks, 0);
    end

    // now at the start of the oc=9 period: align on its tick cycle
    cyc(5);
    rx_align = 1'b1;
    @(negedge clk_in);
    check("align9_clk_high", clk_baud, 1);
    check("align9_no_tick", os_tick, 0);
    check("align9_no_baud", baud_tick, 0);
    cyc(1);
    rx_align = 1'b0;
    #1;
    check("align9_clk_clear", clk_baud, 0);
    wait_tick(n, acks, ack_at);
    check("align9_next_tick", n, 6);

    // freeze for 10 cycles at cc=2
    cyc(2);
    en = 1'b0;
    ot = 0;
    repeat (10) begin
      @(negedge clk_in);
      ot += int'(os_tick) + int'(baud_tick);
    end
    @(posedge clk_in);
    #1;
    check("hold_no_ticks", ot, 0);
    en = 1'b1;
    wait_tick(n, acks, ack_at);
    check("hold_resume", n, 4);

    // divisor 0 acked by en low, clamps to 2
    div_int = 16'd0; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0; en = 1'b0;
    @(negedge clk_in);
    check("en_low_ack", div_ack, 1);
    cyc(1);
    en = 1'b1; rx_align = 1'b1;
    cyc(1);
    rx_align = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_tick(n, acks, ack_at);
      check("d0_clamp_period", n, 2);
    end

`ifdef BAUD_FRAC_EN
    div_int = 16'd4; div_frac = 4'd8; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0; rx_align = 1'b1;
    cyc(1);
    rx_align = 1'b0;
    wait_tick(n, acks, ack_at);
    check("frac_first", n, 4);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(n, acks, ack_at);
      total += n;
    end
    check("frac_16_periods", total, 72);
    div_frac = 4'd0;
`else
    total = 0;
`endif

    // reset in the cc=3 tick cycle while a load is pending
    div_int = 16'd4; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0; rx_align = 1'b1;
    cyc(1);
    rx_align = 1'b0;
    cyc(1);
    div_int = 16'd9; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    cyc(1);
    check("rst_pre_tick", os_tick, 1);
    check("rst_pre_ack", div_ack, 1);
    rst_in = 1'b1;
    #1;
    check("rst_async_tick", os_tick, 0);
    check("rst_async_ack", div_ack, 0);
    check("rst_async_baud", baud_tick, 0);
    check("rst_async_clk", clk_baud, 0);
    cyc(2);
    rst_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_tick(n, acks, ack_at);
      check("post_rst_period", n, 325);
      check("post_rst_no_ack", acks, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
